mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Arbitrates a CPU instruction-fetch port and a data port onto a single SPI
// memory controller (flash for instructions, PSRAM for data). Data requests
// win over fetches. A one-word fetch buffer serves repeated fetches of the
// same 16-bit word without touching the SPI bus.
//
// Ports
//   clk_in, reset_in         : clock, synchronous active-high reset
//   if_req_in / if_addr_in   : fetch request (held until if_ready_out), byte addr
//   if_data_out              : fetched word, [15:8] even byte, [7:0] odd byte
//   if_ready_out             : one-cycle fetch-complete pulse
//   d_req_in / d_we_in       : data request (held until d_ready_out), 1 = write
//   d_addr_in / d_wdata_in   : data byte address / write byte
//   d_rdata_out              : read byte
//   d_ready_out              : one-cycle data-complete pulse
//   mem_addr_out             : address to the SPI controller
//   mem_addr_valid_out       : one-cycle request strobe to the controller
//   mem_type_out             : IMEM read, DMEM read or DMEM write
//   mem_wdata_out            : PSRAM write byte
//   mem_flash_data_in/valid  : flash word and its valid pulse
//   mem_psram_data_in/valid  : PSRAM byte and its valid pulse
//   mem_busy_in              : controller busy
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        TYPE_IMEM_READ  = 2'd0,
        TYPE_DMEM_READ  = 2'd1,
        TYPE_DMEM_WRITE = 2'd2
    } mem_type_t;
endpackage

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        if_req_in,
    input  logic [15:0] if_addr_in,
    output logic [15:0] if_data_out,
    output logic        if_ready_out,
    input  logic        d_req_in,
    input  logic        d_we_in,
    input  logic [15:0] d_addr_in,
    input  logic [7:0]  d_wdata_in,
    output logic [7:0]  d_rdata_out,
    output logic        d_ready_out,
    output logic [15:0] mem_addr_out,
    output logic        mem_addr_valid_out,
    output mem_type_t   mem_type_out,
    output logic [7:0]  mem_wdata_out,
    input  logic [15:0] mem_flash_data_in,
    input  logic        mem_flash_valid_in,
    input  logic [7:0]  mem_psram_data_in,
    input  logic        mem_psram_valid_in,
    input  logic        mem_busy_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Fetch buffer: one flash word, tagged by its word address.
    logic        buf_valid_q, buf_valid_d;
    logic [15:1] buf_addr_q,  buf_addr_d;
    logic [15:0] buf_data_q,  buf_data_d;

    // Set for the first WAIT cycle: the controller raises busy one cycle after
    // the strobe, so a write must not complete on the stale busy=0 it sees then.
    logic        wait_first_q, wait_first_d;

    // Next values of the registered outputs.
    logic [15:0] if_data_d;
    logic        if_ready_d;
    logic [7:0]  d_rdata_d;
    logic        d_ready_d;
    logic [15:0] mem_addr_d;
    logic        mem_addr_valid_d;
    mem_type_t   mem_type_d;
    logic [7:0]  mem_wdata_d;

    logic        fetch_hit;

    // Fetches are word-granular; the byte-select bit plays no part.
    logic        unused_if_addr_bit0;
    assign unused_if_addr_bit0 = if_addr_in[0];

    assign fetch_hit = buf_valid_q && (buf_addr_q == if_addr_in[15:1]);

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        buf_valid_d      = buf_valid_q;
        buf_addr_d       = buf_addr_q;
        buf_data_d       = buf_data_q;
        wait_first_d     = 1'b0;
        if_data_d        = if_data_out;
        if_ready_d       = 1'b0;
        d_rdata_d        = d_rdata_out;
        d_ready_d        = 1'b0;
        mem_addr_d       = mem_addr_out;
        mem_addr_valid_d = 1'b0;
        mem_type_d       = mem_type_out;
        mem_wdata_d      = mem_wdata_out;

        case (state_q)
            IDLE: begin
                // While the controller is busy nothing is accepted at all.
                if (!mem_busy_in) begin
                    if (d_req_in) begin
                        mem_addr_d       = d_addr_in;
                        mem_wdata_d      = d_wdata_in;
                        mem_addr_valid_d = 1'b1;
                        if (d_we_in) begin
                            mem_type_d = TYPE_DMEM_WRITE;
                        end else begin
                            mem_type_d = TYPE_DMEM_READ;
                        end
                        state_d = ISSUE;
                    end else if (if_req_in) begin
                        if (fetch_hit) begin
                            if_data_d  = buf_data_q;
                            if_ready_d = 1'b1;
                            state_d    = RESP;
                        end else begin
                            mem_addr_d       = {if_addr_in[15:1], 1'b0};
                            mem_type_d       = TYPE_IMEM_READ;
                            mem_addr_valid_d = 1'b1;
                            state_d          = ISSUE;
                        end
                    end
                end
            end

            ISSUE: begin
                wait_first_d = 1'b1;
                state_d      = WAIT;
            end

            WAIT: begin
                // Only the valid pulse matching the outstanding type counts.
                case (mem_type_out)
                    TYPE_IMEM_READ: begin
                        if (mem_flash_valid_in) begin
                            if_data_d   = mem_flash_data_in;
                            buf_data_d  = mem_flash_data_in;
                            buf_addr_d  = mem_addr_out[15:1];
                            buf_valid_d = 1'b1;
                            if_ready_d  = 1'b1;
                            state_d     = RESP;
                        end
                    end
                    TYPE_DMEM_READ: begin
                        if (mem_psram_valid_in) begin
                            d_rdata_d = mem_psram_data_in;
                            d_ready_d = 1'b1;
                            state_d   = RESP;
                        end
                    end
                    default: begin
                        if (!wait_first_q && !mem_busy_in) begin
                            d_ready_d = 1'b1;
                            state_d   = RESP;
                        end
                    end
                endcase
            end

            RESP: begin
                // The CPU still holds req this cycle; it is not a new request.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q            <= IDLE;
            buf_valid_q        <= 1'b0;
            buf_addr_q         <= '0;
            wait_first_q       <= 1'b0;
            if_data_out        <= '0;
            if_ready_out       <= 1'b0;
            d_rdata_out        <= '0;
            d_ready_out        <= 1'b0;
            mem_addr_out       <= '0;
            mem_addr_valid_out <= 1'b0;
            mem_type_out       <= TYPE_IMEM_READ;
            mem_wdata_out      <= '0;
        end else begin
            state_q            <= state_d;
            buf_valid_q        <= buf_valid_d;
            buf_addr_q         <= buf_addr_d;
            wait_first_q       <= wait_first_d;
            if_data_out        <= if_data_d;
            if_ready_out       <= if_ready_d;
            d_rdata_out        <= d_rdata_d;
            d_ready_out        <= d_ready_d;
            mem_addr_out       <= mem_addr_d;
            mem_addr_valid_out <= mem_addr_valid_d;
            mem_type_out       <= mem_type_d;
            mem_wdata_out      <= mem_wdata_d;
        end
    end

    // NOTE: the buffer payload is storage qualified by buf_valid_q, so it is
    // deliberately left out of reset.
    always_ff @(posedge clk_in) begin
        buf_data_q <= buf_data_d;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter. A behavioural model predicts, per
// CPU operation, which controller strobes and which ready responses must
// appear; a monitor compares them as the DUT produces them. A simple SPI
// controller model serves strobes with random latency and injects stray
// valid pulses of the wrong type.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        if_req_in;
    logic [15:0] if_addr_in;
    logic [15:0] if_data_out;
    logic        if_ready_out;
    logic        d_req_in;
    logic        d_we_in;
    logic [15:0] d_addr_in;
    logic [7:0]  d_wdata_in;
    logic [7:0]  d_rdata_out;
    logic        d_ready_out;
    logic [15:0] mem_addr_out;
    logic        mem_addr_valid_out;
    mem_type_t   mem_type_out;
    logic [7:0]  mem_wdata_out;
    logic [15:0] mem_flash_data_in;
    logic        mem_flash_valid_in;
    logic [7:0]  mem_psram_data_in;
    logic        mem_psram_valid_in;
    logic        mem_busy_in;

    logic ctl_busy;
    logic ext_busy;
    logic ctl_slow;
    assign mem_busy_in = ctl_busy | ext_busy;

    always #5 clk_in = ~clk_in;

    mem_bus_arbiter dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .if_req_in          (if_req_in),
        .if_addr_in         (if_addr_in),
        .if_data_out        (if_data_out),
        .if_ready_out       (if_ready_out),
        .d_req_in           (d_req_in),
        .d_we_in            (d_we_in),
        .d_addr_in          (d_addr_in),
        .d_wdata_in         (d_wdata_in),
        .d_rdata_out        (d_rdata_out),
        .d_ready_out        (d_ready_out),
        .mem_addr_out       (mem_addr_out),
        .mem_addr_valid_out (mem_addr_valid_out),
        .mem_type_out       (mem_type_out),
        .mem_wdata_out      (mem_wdata_out),
        .mem_flash_data_in  (mem_flash_data_in),
        .mem_flash_valid_in (mem_flash_valid_in),
        .mem_psram_data_in  (mem_psram_data_in),
        .mem_psram_valid_in (mem_psram_valid_in),
        .mem_busy_in        (mem_busy_in)
    );

    // ---------------- counters and helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int strobe_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: required event did not occur within its cycle budget", name);
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [15:0] flash_word(input logic [15:0] wa);
        if (wa == 16'h0010) return 16'hA55A;
        return {wa[7:0] ^ 8'h3C, wa[15:8] ^ wa[7:0] ^ 8'h96};
    endfunction

    function automatic logic [7:0] psram_init(input logic [15:0] a);
        if (a == 16'h8003) return 8'h3C;
        return a[7:0] ^ 8'h5A;
    endfunction

    logic [7:0] ctl_psram [logic [15:0]];
    logic [7:0] ref_psram [logic [15:0]];

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        mem_type_t   typ;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } strobe_t;

    typedef struct {
        bit          is_data;
        logic [15:0] data;
    } resp_t;

    strobe_t exp_strobe_q[$];
    resp_t   exp_resp_q[$];

    bit          m_buf_valid;
    logic [15:0] m_buf_addr;
    logic [15:0] m_buf_data;
    logic [7:0]  m_rdata;

    task automatic model_reset();
        m_buf_valid = 1'b0;
        m_buf_addr  = '0;
        m_buf_data  = '0;
        m_rdata     = '0;
    endtask

    task automatic model_fetch(input logic [15:0] a);
        logic [15:0] wa;
        wa = {a[15:1], 1'b0};
        if (!(m_buf_valid && m_buf_addr == wa)) begin
            exp_strobe_q.push_back('{typ: TYPE_IMEM_READ, addr: wa, wdata: 8'h00});
            m_buf_valid = 1'b1;
            m_buf_addr  = wa;
            m_buf_data  = flash_word(wa);
        end
        exp_resp_q.push_back('{is_data: 1'b0, data: m_buf_data});
    endtask

    task automatic model_data(input bit we, input logic [15:0] a, input logic [7:0] wd);
        if (we) begin
            exp_strobe_q.push_back('{typ: TYPE_DMEM_WRITE, addr: a, wdata: wd});
            ref_psram[a] = wd;
        end else begin
            exp_strobe_q.push_back('{typ: TYPE_DMEM_READ, addr: a, wdata: wd});
            m_rdata = ref_psram.exists(a) ? ref_psram[a] : psram_init(a);
        end
        exp_resp_q.push_back('{is_data: 1'b1, data: {8'h00, m_rdata}});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        strobe_t s;
        resp_t   r;
        if (!reset_in) begin
            if (mem_addr_valid_out) begin
                strobe_count++;
                if (exp_strobe_q.size() == 0) begin
                    check("unexpected_strobe_addr", {16'h0, mem_addr_out}, 32'hFFFF_FFFF);
                end else begin
                    s = exp_strobe_q.pop_front();
                    check("strobe_type", 32'(mem_type_out), 32'(s.typ));
                    check("strobe_addr", {16'h0, mem_addr_out}, {16'h0, s.addr});
                    if (s.typ == TYPE_DMEM_WRITE)
                        check("strobe_wdata", {24'h0, mem_wdata_out}, {24'h0, s.wdata});
                end
            end
            if (if_ready_out && d_ready_out)
                check("both_ready_same_cycle", 32'd1, 32'd0);
            if (if_ready_out) begin
                if (exp_resp_q.size() == 0) begin
                    check("unexpected_if_ready_data", {16'h0, if_data_out}, 32'hFFFF_FFFF);
                end else begin
                    r = exp_resp_q.pop_front();
                    check("resp_order_is_fetch", {31'h0, r.is_data}, 32'd0);
                    check("if_data", {16'h0, if_data_out}, {16'h0, r.data});
                end
            end
            if (d_ready_out) begin
                if (exp_resp_q.size() == 0) begin
                    check("unexpected_d_ready_data", {24'h0, d_rdata_out}, 32'hFFFF_FFFF);
                end else begin
                    r = exp_resp_q.pop_front();
                    check("resp_order_is_data", {31'h0, r.is_data}, 32'd1);
                    check("d_rdata", {24'h0, d_rdata_out}, {16'h0, r.data});
                end
            end
        end
    end

    // ---------------- SPI controller model ----------------
    initial begin
        mem_type_t   c_type;
        logic [15:0] c_addr;
        logic [7:0]  c_wdata;
        int          lat;
        bit          aborted;
        ctl_busy           = 1'b0;
        mem_flash_valid_in = 1'b0;
        mem_psram_valid_in = 1'b0;
        mem_flash_data_in  = '0;
        mem_psram_data_in  = '0;
        forever begin
            @(negedge clk_in);
            if (!reset_in && mem_addr_valid_out) begin
                c_type  = mem_type_out;
                c_addr  = mem_addr_out;
                c_wdata = mem_wdata_out;
                lat     = ctl_slow ? 30 : int'($urandom_range(1, 5));
                aborted = 1'b0;
                @(posedge clk_in);
                #1 ctl_busy = 1'b1;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk_in);
                    #1;
                    mem_flash_valid_in = 1'b0;
                    mem_psram_valid_in = 1'b0;
                    if (reset_in) begin
                        aborted = 1'b1;
                        break;
                    end
                    // Stray pulse of the type that is not outstanding.
                    if ($urandom_range(0, 2) == 0) begin
                        mem_flash_data_in = 16'($urandom);
                        mem_psram_data_in = 8'($urandom);
                        if (c_type == TYPE_IMEM_READ)      mem_psram_valid_in = 1'b1;
                        else if (c_type == TYPE_DMEM_READ) mem_flash_valid_in = 1'b1;
                        else if ($urandom_range(0, 1) == 0) mem_flash_valid_in = 1'b1;
                        else                                mem_psram_valid_in = 1'b1;
                    end
                end
                mem_flash_valid_in = 1'b0;
                mem_psram_valid_in = 1'b0;
                if (aborted) begin
                    ctl_busy = 1'b0;
                end else begin
                    case (c_type)
                        TYPE_IMEM_READ: begin
                            mem_flash_data_in  = flash_word(c_addr);
                            mem_flash_valid_in = 1'b1;
                            ctl_busy           = 1'b0;
                            @(posedge clk_in);
                            #1 mem_flash_valid_in = 1'b0;
                        end
                        TYPE_DMEM_READ: begin
                            mem_psram_data_in  = ctl_psram.exists(c_addr) ? ctl_psram[c_addr]
                                                                          : psram_init(c_addr);
                            mem_psram_valid_in = 1'b1;
                            ctl_busy           = 1'b0;
                            @(posedge clk_in);
                            #1 mem_psram_valid_in = 1'b0;
                        end
                        default: begin
                            ctl_psram[c_addr] = c_wdata;
                            ctl_busy          = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- CPU driver ----------------
    // Returns the number of clock edges from raising req to seeing ready.
    task automatic wait_ready(input bit want_data, output int edges);
        int c;
        c = 0;
        forever begin
            @(negedge clk_in);
            c++;
            if (want_data ? d_ready_out : if_ready_out) break;
            if (c > 200) begin
                fail_event(want_data ? "d_ready_timeout" : "if_ready_timeout");
                break;
            end
        end
        edges = c - 1;
    endtask

    task automatic do_fetch(input logic [15:0] a, output int edges);
        model_fetch(a);
        if_addr_in = a;
        if_req_in  = 1'b1;
        wait_ready(1'b0, edges);
        @(posedge clk_in);
        #1 if_req_in = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [15:0] a, input logic [7:0] wd);
        int edges;
        model_data(we, a, wd);
        d_we_in    = we;
        d_addr_in  = a;
        d_wdata_in = wd;
        d_req_in   = 1'b1;
        wait_ready(1'b1, edges);
        @(posedge clk_in);
        #1 d_req_in = 1'b0;
    endtask

    task automatic do_both(input bit we, input logic [15:0] da, input logic [7:0] wd,
                           input logic [15:0] fa);
        bit dd, fd, drop_d, drop_f;
        model_data(we, da, wd);
        model_fetch(fa);
        dd = 1'b0;
        fd = 1'b0;
        d_we_in    = we;
        d_addr_in  = da;
        d_wdata_in = wd;
        if_addr_in = fa;
        d_req_in   = 1'b1;
        if_req_in  = 1'b1;
        for (int c = 0; c < 400 && !(dd && fd); c++) begin
            @(negedge clk_in);
            drop_d = d_ready_out;
            drop_f = if_ready_out;
            @(posedge clk_in);
            #1;
            if (drop_d) begin
                d_req_in = 1'b0;
                dd = 1'b1;
            end
            if (drop_f) begin
                check("data_served_before_fetch", {31'h0, dd}, 32'd1);
                if_req_in = 1'b0;
                fd = 1'b1;
            end
        end
        if (!(dd && fd)) begin
            fail_event("both_requests_timeout");
            d_req_in  = 1'b0;
            if_req_in = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_if_data"},    {16'h0, if_data_out},  32'h0);
        check({tag, "_if_ready"},   {31'h0, if_ready_out}, 32'h0);
        check({tag, "_d_rdata"},    {24'h0, d_rdata_out},  32'h0);
        check({tag, "_d_ready"},    {31'h0, d_ready_out},  32'h0);
        check({tag, "_mem_addr"},   {16'h0, mem_addr_out}, 32'h0);
        check({tag, "_mem_valid"},  {31'h0, mem_addr_valid_out}, 32'h0);
        check({tag, "_mem_type"},   32'(mem_type_out), 32'(TYPE_IMEM_READ));
        check({tag, "_mem_wdata"},  {24'h0, mem_wdata_out}, 32'h0);
    endtask

    task automatic run_random(input int n);
        logic [15:0] last_fetch;
        logic [15:0] fa, da;
        logic [7:0]  wd;
        int          op, edges;
        last_fetch = 16'h0010;
        for (int it = 0; it < n; it++) begin
            op = int'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) fa = last_fetch ^ 16'($urandom_range(0, 1));
            else                           fa = 16'($urandom_range(0, 63));
            da = 16'h8000 + 16'($urandom_range(0, 31));
            wd = 8'($urandom);
            case (op)
                0, 1, 2: begin
                    do_fetch(fa, edges);
                    last_fetch = fa;
                end
                3: do_data(1'b0, da, wd);
                4: do_data(1'b1, da, wd);
                default: begin
                    do_both($urandom_range(0, 1) == 1, da, wd, fa);
                    last_fetch = fa;
                end
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk_in);
            #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s0, edges;
        bit seen;
        reset_in   = 1'b1;
        if_req_in  = 1'b0;
        if_addr_in = '0;
        d_req_in   = 1'b0;
        d_we_in    = 1'b0;
        d_addr_in  = '0;
        d_wdata_in = '0;
        ext_busy   = 1'b0;
        ctl_slow   = 1'b0;
        model_reset();

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_values("reset");
        @(posedge clk_in);
        #1 reset_in = 1'b0;

        // Cold fetch misses, then the neighbouring byte hits the buffer.
        s0 = strobe_count;
        do_fetch(16'h0010, edges);
        check("cold_fetch_strobes", 32'(strobe_count - s0), 32'd1);
        s0 = strobe_count;
        do_fetch(16'h0011, edges);
        check("hit_fetch_strobes", 32'(strobe_count - s0), 32'd0);
        check("hit_fetch_latency", 32'(edges), 32'd1);

        // A PSRAM write leaves the fetch buffer intact.
        do_data(1'b1, 16'h8100, 8'h77);
        s0 = strobe_count;
        do_fetch(16'h0010, edges);
        check("hit_after_write_strobes", 32'(strobe_count - s0), 32'd0);

        // Simultaneous requests: data first, then the fetch.
        do_both(1'b0, 16'h8003, 8'h00, 16'h0020);

        // Request held off while the controller is busy.
        ext_busy = 1'b1;
        model_fetch(16'h0032);
        if_addr_in = 16'h0032;
        if_req_in  = 1'b1;
        repeat (4) begin
            @(negedge clk_in);
            check("no_strobe_while_busy", {31'h0, mem_addr_valid_out}, 32'd0);
        end
        @(posedge clk_in);
        #1 ext_busy = 1'b0;
        @(negedge clk_in);
        check("no_strobe_before_idle_sample", {31'h0, mem_addr_valid_out}, 32'd0);
        @(negedge clk_in);
        check("strobe_after_busy_drop", {31'h0, mem_addr_valid_out}, 32'd1);
        wait_ready(1'b0, edges);
        @(posedge clk_in);
        #1 if_req_in = 1'b0;

        // Reset during WAIT of a fetch abandons it.
        ctl_slow = 1'b1;
        exp_strobe_q.push_back('{typ: TYPE_IMEM_READ, addr: 16'h0040, wdata: 8'h00});
        if_addr_in = 16'h0040;
        if_req_in  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_in);
            seen = mem_addr_valid_out;
        end
        if (!seen) fail_event("reset_test_strobe");
        @(posedge clk_in);
        #1;
        reset_in  = 1'b1;
        if_req_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check_reset_values("wait_reset");
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        ctl_slow = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        check("no_if_ready_after_abort", {31'h0, if_ready_out}, 32'd0);
        @(posedge clk_in);
        #1;
        s0 = strobe_count;
        do_fetch(16'h0040, edges);
        check("fetch_after_reset_strobes", 32'(strobe_count - s0), 32'd1);

        run_random(60);

        repeat (10) @(posedge clk_in);
        check("strobes_outstanding", 32'(exp_strobe_q.size()), 32'd0);
        check("responses_outstanding", 32'(exp_resp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
